unary_binary_mac_arbiter: RTL

//   Shares one unary_binary_MAC_W instance (out = a*b + c, multi-cycle, valid/ready) among
//   N requesters. Round-robin grant, operand capture, single-cycle MAC launch, result capture,
//   and return of the result tagged with the requester index over a valid/ready response port.

---
 rtl/unary_binary_mac_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/unary_binary_mac_arbiter.sv
// unary_binary_mac_arbiter: round-robin share of one multi-cycle MAC (a*b+c) among N requesters
// Ports: clk, reset_n (async active-low); req_valid/req_ready/req_a/req_b/req_c request side;
//   rsp_valid/rsp_ready/rsp_id/rsp_out/rsp_err response side; mac_valid/mac_a/mac_b/mac_c launch
//   and mac_ready/mac_out result from the MAC; busy while a transaction is in flight.
// Define UB_MAC_ARB_TIMEOUT_EN to abort WAIT after TIMEOUT cycles with rsp_err=1, rsp_out=0.
module unary_binary_mac_arbiter #(
  parameter int N       = 4,
  parameter int W       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N-1:0]         req_valid,
  output logic [N-1:0]         req_ready,
  input  logic [N*W-1:0]       req_a,
  input  logic [N*W-1:0]       req_b,
  input  logic [N*W-1:0]       req_c,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [$clog2(N)-1:0] rsp_id,
  output logic [2*W-1:0]       rsp_out,
  output logic                 rsp_err,
  output logic                 mac_valid,
  output logic [W-1:0]         mac_a,
  output logic [W-1:0]         mac_b,
  output logic [W-1:0]         mac_c,
  input  logic                 mac_ready,
  input  logic [2*W-1:0]       mac_out,
  output logic                 busy
);
  localparam int IW = $clog2(N);
  localparam logic [IW:0] NN = (IW+1)'(N);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  state_e state_q, state_d;
  logic [IW-1:0] rr_q, rr_d, id_q, id_d, win;
  logic [IW:0] s;
  logic hit;
  logic [W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [2*W-1:0] out_q, out_d;
`ifdef UB_MAC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT+1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
`endif
  // descending scan so the requester closest to rr_q is the last (winning) assignment
  always_comb begin
    win = '0;
    hit = 1'b0;
    s = '0;
    for (int k = N-1; k >= 0; k--) begin
      s = {1'b0, rr_q} + (IW+1)'(k);
      if (s >= NN) s = s - NN;
      if (req_valid[IW'(s)]) begin
        win = IW'(s);
        hit = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    id_d = id_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    out_d = out_q;
`ifdef UB_MAC_ARB_TIMEOUT_EN
    cnt_d = cnt_q;
    err_d = err_q;
`endif
    case (state_q)
      IDLE: if (hit) begin
        state_d = ISSUE;
        id_d = win;
        rr_d = (win == IW'(N-1)) ? '0 : win + 1'b1;
        a_d = req_a[win*W +: W];
        b_d = req_b[win*W +: W];
        c_d = req_c[win*W +: W];
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef UB_MAC_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      WAIT: if (mac_ready) begin
        state_d = RESP;
        out_d = mac_out;
`ifdef UB_MAC_ARB_TIMEOUT_EN
        err_d = 1'b0;
      end else if (cnt_q == CW'(TIMEOUT-1)) begin
        state_d = RESP;
        out_d = '0;
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
`endif
      end
      default: if (rsp_ready) state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rr_q <= '0;
      id_q <= '0;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      out_q <= '0;
`ifdef UB_MAC_ARB_TIMEOUT_EN
      cnt_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      id_q <= id_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      out_q <= out_d;
`ifdef UB_MAC_ARB_TIMEOUT_EN
      cnt_q <= cnt_d;
      err_q <= err_d;
`endif
    end
  end
  assign req_ready = (state_q == IDLE && hit) ? {{(N-1){1'b0}}, 1'b1} << win : '0;
  assign mac_valid = state_q == ISSUE;
  assign rsp_valid = state_q == RESP;
  assign busy = state_q != IDLE;
  assign rsp_id = id_q;
  assign rsp_out = out_q;
  assign mac_a = a_q;
  assign mac_b = b_q;
  assign mac_c = c_q;
`ifdef UB_MAC_ARB_TIMEOUT_EN
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif
endmodule
